// File: rtl/mac_host_pkg.sv
// Shared types and constants for the MAC host agent and its result collector.
package mac_host_pkg;

  localparam int unsigned ACT_W = 4;
  localparam int unsigned ACC_W = 12;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_RUN    = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_TIMEOUT = 2'd1;
  localparam logic [1:0] ERR_BEATS   = 2'd2;
  localparam logic [1:0] ERR_ROWIDX  = 2'd3;

  typedef logic [0:7][ACT_W-1:0] act_row_t;
  typedef logic [0:8][ACT_W-1:0] wgt_row_t;
  typedef logic [0:7][ACC_W-1:0] res_row_t;

  // First error wins; a later event never overwrites a recorded code.
  function automatic logic [1:0] err_merge(input logic [1:0] cur, input logic [1:0] nxt);
    return (cur != ERR_NONE) ? cur : nxt;
  endfunction

endpackage

// File: rtl/mac_host_agent_if.sv
// Host <-> MAC array signal bundle; master is the host agent, slave is the MAC.
interface mac_host_agent_if;
  logic        mac_in_valid;
  logic        mac_in_mode;
  logic [31:0] mac_in_act;
  logic [35:0] mac_in_wgt;
  logic [3:0]  mac_act_idx;
  logic [3:0]  mac_wgt_idx;
  logic        mac_out_valid;
  logic [3:0]  mac_out_idx;
  logic [95:0] mac_out_data;
  logic        mac_out_finish;

  modport master (
    output mac_in_valid, mac_in_mode, mac_in_act, mac_in_wgt,
    input  mac_act_idx, mac_wgt_idx, mac_out_valid, mac_out_idx, mac_out_data, mac_out_finish
  );

  modport slave (
    input  mac_in_valid, mac_in_mode, mac_in_act, mac_in_wgt,
    output mac_act_idx, mac_wgt_idx, mac_out_valid, mac_out_idx, mac_out_data, mac_out_finish
  );
endinterface

// File: rtl/mac_result_collector.sv
// Counts result beats, checks per-row index stability and writes completed rows
// into the readable result buffer.
module mac_result_collector
  import mac_host_pkg::*;
#(
  parameter int unsigned NROW = 8,
  parameter int unsigned NCOL = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear,
  input  logic       run,
  input  logic       beat_valid,
  input  logic [3:0] beat_idx,
  input  res_row_t   beat_data,
  input  logic       finish,
  input  logic [2:0] rd_addr,
  output res_row_t   rd_data,
  output logic       idx_err,
  output logic       cnt_err
);

  logic [6:0] beat_cnt;
  logic [2:0] row_beat;
  logic [3:0] row_idx;
  logic       row_bad;
  res_row_t   result [8];

  logic beat, mid_row, row_done;

  assign beat     = run && beat_valid;
  assign mid_row  = (row_beat != 3'd0);
  assign row_done = beat && (row_beat == 3'(NCOL - 1));
  assign idx_err  = beat && mid_row && (beat_idx != row_idx);
  // The finishing cycle's own beat counts toward the total.
  assign cnt_err  = run && finish && (7'(beat_cnt + 7'(beat)) != 7'(NROW * NCOL));
  assign rd_data  = result[rd_addr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_cnt <= '0;
      row_beat <= '0;
      row_idx  <= '0;
      row_bad  <= 1'b0;
    end else if (clear) begin
      beat_cnt <= '0;
      row_beat <= '0;
      row_bad  <= 1'b0;
    end else if (beat) begin
      beat_cnt <= beat_cnt + 7'd1;
      row_beat <= row_beat + 3'd1;
      if (!mid_row) row_idx <= beat_idx;
      if (row_done || !mid_row) row_bad <= 1'b0;
      else                      row_bad <= row_bad || idx_err;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < 8; i++) result[i] <= '0;
    end else if (row_done && !row_bad && !idx_err) begin
      result[row_idx[2:0]] <= beat_data;
    end
  end

endmodule

// File: rtl/mac_host_agent.sv
// Host-side agent for the MAC array: operand register files, job-launch FSM,
// timeout supervision and the result buffer via mac_result_collector.
module mac_host_agent
  import mac_host_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned NROW    = 8,
  parameter int unsigned NCOL    = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_we,
  input  logic              cfg_sel,
  input  logic [3:0]        cfg_addr,
  input  logic [35:0]       cfg_wdata,
  input  logic              start,
  input  logic              mode,
  output logic              busy,
  output logic              done,
  output logic [1:0]        err,
  input  logic [2:0]        rd_addr,
  output logic [95:0]       rd_data,
  mac_host_agent_if.master  mac
);

  localparam int unsigned TO_W = $clog2(TIMEOUT + 1);

  state_e          state;
  logic            mode_q;
  logic [TO_W-1:0] to_cnt;
  act_row_t        act_file [16];
  wgt_row_t        wgt_file [16];

  logic       cfg_open, accept_start, to_hit, idx_err, cnt_err;
  logic [1:0] run_err;
  res_row_t   rd_row;

  assign cfg_open     = (state == ST_IDLE) || (state == ST_DONE);
  assign accept_start = start && cfg_open;
  assign to_hit       = (state == ST_RUN) && !mac.mac_out_valid && (to_cnt == TO_W'(TIMEOUT));

  assign busy             = (state == ST_LAUNCH) || (state == ST_RUN);
  assign done             = (state == ST_DONE);
  assign mac.mac_in_valid = (state == ST_LAUNCH);
  assign mac.mac_in_mode  = (state == ST_LAUNCH) && mode_q;
  assign mac.mac_in_act   = act_file[mac.mac_act_idx];
  assign mac.mac_in_wgt   = wgt_file[mac.mac_wgt_idx];
  assign rd_data          = rd_row;

  always_comb begin
    run_err = ERR_NONE;
    if (idx_err)      run_err = ERR_ROWIDX;
    else if (cnt_err) run_err = ERR_BEATS;
    else if (to_hit)  run_err = ERR_TIMEOUT;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      mode_q <= 1'b0;
      err    <= ERR_NONE;
      to_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state  <= ST_LAUNCH;
            err    <= ERR_NONE;
            to_cnt <= '0;
            mode_q <= mode;
          end
        end
        ST_LAUNCH: state <= ST_RUN;
        ST_RUN: begin
          if (mac.mac_out_valid) to_cnt <= '0;
          else if (!to_hit)      to_cnt <= to_cnt + 1'b1;
          err <= err_merge(err, run_err);
          if (mac.mac_out_finish || to_hit) state <= ST_DONE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Operand files are writable only while no job can be fetching from them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < 16; i++) begin
        act_file[i] <= '0;
        wgt_file[i] <= '0;
      end
    end else if (cfg_we && cfg_open) begin
      if (cfg_sel) wgt_file[cfg_addr] <= wgt_row_t'(cfg_wdata);
      else         act_file[cfg_addr] <= act_row_t'(cfg_wdata[35:4]);
    end
  end

  mac_result_collector #(
    .NROW (NROW),
    .NCOL (NCOL)
  ) u_collector (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (accept_start),
    .run        (state == ST_RUN),
    .beat_valid (mac.mac_out_valid),
    .beat_idx   (mac.mac_out_idx),
    .beat_data  (res_row_t'(mac.mac_out_data)),
    .finish     (mac.mac_out_finish),
    .rd_addr    (rd_addr),
    .rd_data    (rd_row),
    .idx_err    (idx_err),
    .cnt_err    (cnt_err)
  );

endmodule

// File: tb/tb_mac_host_agent.sv
// Self-checking bench for mac_host_agent with a behavioural MAC array model.
module tb_mac_host_agent;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cfg_we = 1'b0, cfg_sel = 1'b0;
  logic [3:0]  cfg_addr = '0;
  logic [35:0] cfg_wdata = '0;
  logic        start = 1'b0, mode = 1'b0;
  logic        busy, done;
  logic [1:0]  err;
  logic [2:0]  rd_addr = '0;
  logic [95:0] rd_data;

  mac_host_agent_if mif ();

  mac_host_agent #(.TIMEOUT(255), .NROW(8), .NCOL(8)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_addr(cfg_addr),
    .cfg_wdata(cfg_wdata), .start(start), .mode(mode), .busy(busy), .done(done), .err(err),
    .rd_addr(rd_addr), .rd_data(rd_data), .mac(mif)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0, pulses = 0;
  int sa [16][8];
  int sw [16][9];
  int fa [16][8];
  int fw [16][9];
  logic [95:0] exp_buf [8];

  always @(negedge clk) if (mif.mac_in_valid) pulses++;

  task automatic chk(input string tag, input logic [95:0] got, input logic [95:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Matrix multiply: act rows 0-7 times wgt rows 8-15.
  // Convolution: 8x8 image in act rows 0-7, 3x3 kernel in wgt row 0, zero padded.
  function automatic int mac_elem(input bit use_fetch, input bit m, input int i, input int j);
    int s, a, w, r, c;
    s = 0;
    if (!m) begin
      for (int k = 0; k < 8; k++) begin
        a = use_fetch ? fa[i][k] : sa[i][k];
        w = use_fetch ? fw[8+k][j] : sw[8+k][j];
        s += a * w;
      end
    end else begin
      for (int di = 0; di < 3; di++)
        for (int dj = 0; dj < 3; dj++) begin
          r = i + di - 1;
          c = j + dj - 1;
          if (r >= 0 && r < 8 && c >= 0 && c < 8) begin
            a = use_fetch ? fa[r][c] : sa[r][c];
            w = use_fetch ? fw[0][di*3+dj] : sw[0][di*3+dj];
            s += a * w;
          end
        end
    end
    return s;
  endfunction

  function automatic logic [95:0] ref_row(input bit m, input int r);
    logic [95:0] row;
    row = '0;
    for (int j = 0; j < 8; j++) row[95-12*j -: 12] = 12'(mac_elem(1'b0, m, r, j));
    return row;
  endfunction

  task automatic cfg_wr(input bit sel, input int addr, input logic [35:0] d, input bit taken);
    @(negedge clk);
    cfg_we = 1'b1; cfg_sel = sel; cfg_addr = 4'(addr); cfg_wdata = d;
    @(negedge clk);
    cfg_we = 1'b0;
    if (taken) begin
      if (sel) for (int k = 0; k < 9; k++) sw[addr][k] = int'(d[35-4*k -: 4]);
      else     for (int k = 0; k < 8; k++) sa[addr][k] = int'(d[35-4*k -: 4]);
    end
  endtask

  task automatic clear_model();
    for (int r = 0; r < 16; r++) begin
      for (int k = 0; k < 8; k++) sa[r][k] = 0;
      for (int k = 0; k < 9; k++) sw[r][k] = 0;
    end
    for (int r = 0; r < 8; r++) exp_buf[r] = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    clear_model();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic fill_random();
    for (int r = 0; r < 16; r++) begin
      cfg_wr(1'b0, r, {$urandom(), 4'h0}, 1'b1);
      cfg_wr(1'b1, r, {4'($urandom()), $urandom()}, 1'b1);
    end
  endtask

  task automatic check_buf(input string tag);
    for (int r = 0; r < 8; r++) begin
      rd_addr = 3'(r);
      #1;
      chk($sformatf("%s_row%0d", tag, r), rd_data, exp_buf[r]);
    end
  endtask

  // Launches one job, plays the MAC side (fetch, then stream nbeats beats) and
  // checks the completion status and the whole result buffer.
  task automatic do_job(input string tag, input bit m, input int nbeats, input int glitch_row,
                        input bit poke_busy, input logic [1:0] exp_err);
    logic [95:0] win;
    int row, col, waited;
    @(negedge clk);
    pulses = 0;
    start = 1'b1; mode = m;
    @(negedge clk);
    start = 1'b0; mode = 1'b0;
    chk({tag, "_launch_valid"}, 96'(mif.mac_in_valid), 96'(1));
    chk({tag, "_launch_mode"}, 96'(mif.mac_in_mode), 96'(m));
    chk({tag, "_launch_busy"}, 96'(busy), 96'(1));
    for (int r = 0; r < 16; r++) begin
      mif.mac_act_idx = 4'(r);
      mif.mac_wgt_idx = 4'(r);
      #1;
      for (int k = 0; k < 8; k++) fa[r][k] = int'(mif.mac_in_act[31-4*k -: 4]);
      for (int k = 0; k < 9; k++) fw[r][k] = int'(mif.mac_in_wgt[35-4*k -: 4]);
      @(negedge clk);
    end
    if (poke_busy) begin
      start = 1'b1;
      cfg_we = 1'b1; cfg_sel = 1'b0; cfg_addr = 4'd15; cfg_wdata = {$urandom(), 4'h0};
      @(negedge clk);
      start = 1'b0; cfg_we = 1'b0;
    end
    win = '0;
    for (int n = 0; n < nbeats; n++) begin
      row = (n / 8) % 8;
      col = n % 8;
      win = {win[83:0], 12'(mac_elem(1'b1, m, row, col))};
      mif.mac_out_valid  = 1'b1;
      mif.mac_out_idx    = (row == glitch_row && col >= 3) ? 4'(row ^ 1) : 4'(row);
      mif.mac_out_data   = win;
      mif.mac_out_finish = (n == nbeats - 1);
      @(negedge clk);
    end
    mif.mac_out_valid = 1'b0;
    mif.mac_out_finish = 1'b0;
    for (int r = 0; r < 8; r++)
      if ((r + 1) * 8 <= nbeats && r != glitch_row) exp_buf[r] = ref_row(m, r);
    waited = 0;
    while (!done && waited < 400) begin
      @(negedge clk);
      waited++;
    end
    chk({tag, "_done"}, 96'(done), 96'(1));
    chk({tag, "_busy"}, 96'(busy), 96'(0));
    chk({tag, "_err"}, 96'(err), 96'(exp_err));
    chk({tag, "_pulses"}, 96'(pulses), 96'(1));
    check_buf(tag);
  endtask

  initial begin
    mif.mac_act_idx = '0; mif.mac_wgt_idx = '0;
    mif.mac_out_valid = 1'b0; mif.mac_out_idx = '0;
    mif.mac_out_data = '0; mif.mac_out_finish = 1'b0;
    clear_model();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_busy", 96'(busy), 96'(0));
    chk("rst_done", 96'(done), 96'(0));
    chk("rst_err", 96'(err), 96'(0));
    chk("rst_valid", 96'(mif.mac_in_valid), 96'(0));
    chk("rst_mode", 96'(mif.mac_in_mode), 96'(0));
    check_buf("rst_buf");

    // Zero-latency operand fetch.
    cfg_wr(1'b0, 9, {32'h12345678, 4'h0}, 1'b1);
    cfg_wr(1'b1, 3, 36'h9ABCDEF01, 1'b1);
    mif.mac_act_idx = 4'h9; mif.mac_wgt_idx = 4'h3;
    #1;
    chk("fetch_act", 96'(mif.mac_in_act), 96'(32'h12345678));
    chk("fetch_wgt", 96'(mif.mac_in_wgt), 96'(36'h9ABCDEF01));

    for (int r = 0; r < 8; r++) begin
      cfg_wr(1'b0, r, {32'h11111111, 4'h0}, 1'b1);
      cfg_wr(1'b1, 8 + r, 36'h111111111, 1'b1);
    end
    do_job("mm_ones", 1'b0, 64, -1, 1'b1, 2'd0);
    rd_addr = 3'd5; #1;
    chk("mm_ones_elem", 96'(rd_data[95:84]), 96'(8));
    mif.mac_act_idx = 4'd15; #1;
    chk("cfg_ignored_run", 96'(mif.mac_in_act), 96'({sa[15][0][3:0], sa[15][1][3:0], sa[15][2][3:0],
        sa[15][3][3:0], sa[15][4][3:0], sa[15][5][3:0], sa[15][6][3:0], sa[15][7][3:0]}));

    for (int r = 0; r < 8; r++) cfg_wr(1'b0, r, {32'hFFFFFFFF, 4'h0}, 1'b1);
    cfg_wr(1'b1, 0, 36'hFFFFFFFFF, 1'b1);
    do_job("conv_f", 1'b1, 64, -1, 1'b0, 2'd0);
    rd_addr = 3'd3; #1;
    chk("conv_interior", 96'(rd_data[59:48]), 96'(2025));

    for (int t = 0; t < 2; t++) begin
      fill_random();
      do_job($sformatf("rand%0d", t), 1'($urandom()), 64, -1, 1'b0, 2'd0);
    end

    fill_random();
    do_job("short", 1'b0, 40, -1, 1'b0, 2'd2);

    do_reset();
    fill_random();
    do_job("rowidx", 1'b1, 64, 2, 1'b0, 2'd3);

    do_job("timeout", 1'b0, 0, -1, 1'b0, 2'd1);

    // Asynchronous reset in the middle of a job.
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("mid_launch_valid", 96'(mif.mac_in_valid), 96'(1));
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    clear_model();
    #1;
    chk("mid_rst_busy", 96'(busy), 96'(0));
    chk("mid_rst_done", 96'(done), 96'(0));
    chk("mid_rst_valid", 96'(mif.mac_in_valid), 96'(0));
    chk("mid_rst_err", 96'(err), 96'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_busy", 96'(busy), 96'(0));
    check_buf("post_rst_buf");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
